// File: rtl/stream_extremum_tracker_pkg.sv
// Shared types and constants for the streaming extremum tracker.
package stream_extremum_tracker_pkg;

   // Frame FSM states: collecting the first sample, accumulating, presenting the result.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } state_e;

   // Mode encoding shared with the combinational mode comparator.
   localparam logic MODE_MAX = 1'b0;
   localparam logic MODE_MIN = 1'b1;

endpackage

// File: rtl/stream_extremum_tracker_ext_cmp.sv
// Strict "better-than" comparator: greater-than in max mode, less-than in min mode.
// Strictness is what makes the tracker keep the first occurrence on ties.
module ext_cmp
   import stream_extremum_tracker_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int SIGNED = 0
) (
   input  logic [WIDTH-1:0] cand,
   input  logic [WIDTH-1:0] best,
   input  logic             mode,
   output logic             take
);

   logic gt;
   logic lt;

   generate
      if (SIGNED != 0) begin : g_signed
         // Two's-complement ordering on the raw sample bits.
         always_comb begin
            gt = $signed(cand) > $signed(best);
            lt = $signed(cand) < $signed(best);
         end
      end else begin : g_unsigned
         // Plain magnitude ordering.
         always_comb begin
            gt = cand > best;
            lt = cand < best;
         end
      end
   endgenerate

   // Mode picks which strict relation counts as an improvement.
   always_comb begin
      take = (mode == MODE_MIN) ? lt : gt;
   end

endmodule

// File: rtl/stream_extremum_tracker.sv
// Streaming max/min tracker: consumes a frame of samples over valid/ready and
// presents the extremum, its first index, the sample count and the frame mode.
module stream_extremum_tracker
   import stream_extremum_tracker_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int FRAME_LEN = 16,
   parameter int SIGNED    = 0,
   parameter int IDXW      = $clog2(FRAME_LEN),
   parameter int CNTW      = $clog2(FRAME_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mode,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_value,
   output logic [IDXW-1:0]  out_index,
   output logic [CNTW-1:0]  out_count,
   output logic             out_mode,
   output logic             out_valid,
   input  logic             out_ready
);

   state_e           state_q;
   logic [WIDTH-1:0] best_q;
   logic [IDXW-1:0]  best_idx_q;
   logic [CNTW-1:0]  cnt_q;
   logic             frame_mode_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] out_value_q;
   logic [IDXW-1:0]  out_index_q;
   logic [CNTW-1:0]  out_count_q;
   logic             out_mode_q;

   logic             accept;
   logic             take;
   logic [WIDTH-1:0] best_d;
   logic [IDXW-1:0]  best_idx_d;
   logic [CNTW-1:0]  cnt_d;
   logic             frame_mode_d;
   logic             frame_done_d;

   // Candidate is always the incoming sample against the running best of this frame.
   ext_cmp #(
      .WIDTH  (WIDTH),
      .SIGNED (SIGNED)
   ) u_cmp (
      .cand (in_data),
      .best (best_q),
      .mode (frame_mode_q),
      .take (take)
   );

   // Next running state if a sample is accepted this cycle.
   always_comb begin
      accept       = in_valid && in_ready_q;
      best_d       = best_q;
      best_idx_d   = best_idx_q;
      cnt_d        = cnt_q;
      frame_mode_d = frame_mode_q;
      if (state_q == ST_IDLE) begin
         // First sample of a frame seeds the best and latches the mode.
         best_d       = in_data;
         best_idx_d   = '0;
         cnt_d        = CNTW'(1);
         frame_mode_d = mode;
      end else begin
         if (take) begin
            best_d     = in_data;
            best_idx_d = IDXW'(cnt_q);
         end
         cnt_d = cnt_q + CNTW'(1);
      end
      frame_done_d = in_last || (cnt_d == CNTW'(FRAME_LEN));
   end

   // Frame FSM with registered handshake and result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         best_q       <= '0;
         best_idx_q   <= '0;
         cnt_q        <= '0;
         frame_mode_q <= 1'b0;
         in_ready_q   <= 1'b1;
         out_valid_q  <= 1'b0;
         out_value_q  <= '0;
         out_index_q  <= '0;
         out_count_q  <= '0;
         out_mode_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_ACCUM: begin
               if (accept) begin
                  best_q       <= best_d;
                  best_idx_q   <= best_idx_d;
                  cnt_q        <= cnt_d;
                  frame_mode_q <= frame_mode_d;
                  if (frame_done_d) begin
                     state_q     <= ST_HOLD;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                     out_value_q <= best_d;
                     out_index_q <= best_idx_d;
                     out_count_q <= cnt_d;
                     out_mode_q  <= frame_mode_d;
                  end else begin
                     state_q <= ST_ACCUM;
                  end
               end
            end
            ST_HOLD: begin
               // Result stays put until downstream takes it; input reopens next cycle.
               if (out_ready) begin
                  state_q     <= ST_IDLE;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
                  cnt_q       <= '0;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               cnt_q       <= '0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_value = out_value_q;
   assign out_index = out_index_q;
   assign out_count = out_count_q;
   assign out_mode  = out_mode_q;

endmodule
